// File: rtl/pmp_checker.sv
// pmp_checker: physical memory protection checker with a sequential entry scan.
// Each accepted request is compared against one PMP entry per clock, lowest
// index first, and the first entry touching the access span decides the result.
// Optional feature macro: PMP_NAPOT_EN. When it is defined, A=3 decodes as a
// NAPOT region. When it is undefined, A=3 behaves as OFF and the NAPOT decode
// is not built.
module pmp_checker #(
  parameter int NUM_ENTRIES = 8,
  parameter int IDX_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [7:0]       cfg_wdata,
  input  logic             addr_we,
  input  logic [IDX_W-1:0] addr_idx,
  input  logic [31:0]      addr_wdata,
  output logic             cfg_ready,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic [1:0]       req_size,
  input  logic [1:0]       req_type,
  input  logic             req_priv_m,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_allow,
  output logic             rsp_hit,
  output logic [IDX_W-1:0] rsp_hit_idx
);

  localparam logic [1:0] A_TOR   = 2'd1;
  localparam logic [1:0] A_NA4   = 2'd2;
`ifdef PMP_NAPOT_EN
  localparam logic [1:0] A_NAPOT = 2'd3;
`endif

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  state_t state_reg, state_next;

  // Entry configuration {L,2'b0,A,X,W,R} and address registers.
  logic [7:0]  cfg_reg     [NUM_ENTRIES];
  logic [31:0] pmpaddr_reg [NUM_ENTRIES];

  // Captured request and scan position.
  logic [31:0]      addr_reg;
  logic [1:0]       size_reg;
  logic [1:0]       type_reg;
  logic             priv_reg;
  logic [IDX_W-1:0] scan_idx_reg;

  // Reserved cfg bits are stored as zero and never decoded.
  logic unused_cfg_bits;
  assign unused_cfg_bits = ^cfg_wdata[6:5];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
      logic tor_lock;
      logic cfg_wr;
      logic addr_wr;

      // A locked TOR entry above also freezes this entry's address (its lower bound).
      if (gi + 1 < NUM_ENTRIES) begin : g_upper
        assign tor_lock = cfg_reg[gi+1][7] && (cfg_reg[gi+1][4:3] == A_TOR);
      end else begin : g_top
        assign tor_lock = 1'b0;
      end

      // Lock checks use the register values before this cycle's writes.
      assign cfg_wr  = cfg_we && cfg_ready && (cfg_idx == IDX_W'(gi)) && !cfg_reg[gi][7];
      assign addr_wr = addr_we && cfg_ready && (addr_idx == IDX_W'(gi)) &&
                       !cfg_reg[gi][7] && !tor_lock;

      // Per-entry register update; L bits only clear on reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cfg_reg[gi]     <= 8'h00;
          pmpaddr_reg[gi] <= 32'h0;
        end else begin
          if (cfg_wr)  cfg_reg[gi]     <= cfg_wdata & 8'h9F;
          if (addr_wr) pmpaddr_reg[gi] <= addr_wdata;
        end
      end
    end
  endgenerate

  // Entry currently under evaluation.
  logic [7:0]  cur_cfg;
  logic [31:0] cur_addr;
  logic [31:0] prev_addr;
  logic        last_entry;

  assign cur_cfg    = cfg_reg[scan_idx_reg];
  assign cur_addr   = pmpaddr_reg[scan_idx_reg];
  assign prev_addr  = (scan_idx_reg == '0) ? 32'h0 : pmpaddr_reg[scan_idx_reg - 1'b1];
  assign last_entry = (scan_idx_reg == IDX_W'(NUM_ENTRIES - 1));

  // Inclusive byte span of the access, 34-bit so the top never wraps.
  logic [33:0] span_lo, span_hi;
  logic [1:0]  span_len_m1;

  always_comb begin
    case (size_reg)
      2'd0:    span_len_m1 = 2'd0;
      2'd1:    span_len_m1 = 2'd1;
      default: span_len_m1 = 2'd3;
    endcase
  end

  assign span_lo = {2'b00, addr_reg};
  assign span_hi = span_lo + {32'd0, span_len_m1};

  // Region decode of the current entry as an inclusive byte range.
  logic [33:0] reg_lo, reg_hi, tor_top;
  logic        region_valid;
`ifdef PMP_NAPOT_EN
  logic [33:0] napot_mask;
  assign napot_mask = {cur_addr ^ (cur_addr + 32'd1), 2'b11};
`endif

  // Map the A field to a byte range; empty TOR ranges and OFF never match.
  always_comb begin
    region_valid = 1'b0;
    reg_lo       = '0;
    reg_hi       = '0;
    tor_top      = {cur_addr, 2'b00};
    case (cur_cfg[4:3])
      A_TOR: begin
        reg_lo       = {prev_addr, 2'b00};
        reg_hi       = tor_top - 34'd1;
        region_valid = (tor_top > reg_lo);
      end
      A_NA4: begin
        reg_lo       = {cur_addr, 2'b00};
        reg_hi       = reg_lo + 34'd3;
        region_valid = 1'b1;
      end
`ifdef PMP_NAPOT_EN
      A_NAPOT: begin
        reg_lo       = {cur_addr, 2'b00} & ~napot_mask;
        reg_hi       = reg_lo | napot_mask;
        region_valid = 1'b1;
      end
`endif
      default: region_valid = 1'b0;
    endcase
  end

  logic full_match, any_match, perm_bit, entry_allow, size_bad;

  assign full_match = region_valid && (span_lo >= reg_lo) && (span_hi <= reg_hi);
  assign any_match  = region_valid && (span_lo <= reg_hi) && (span_hi >= reg_lo);
  assign size_bad   = (size_reg == 2'd3);

  // Pick the permission bit for the access type; type 3 grants nothing.
  always_comb begin
    case (type_reg)
      2'd0:    perm_bit = cur_cfg[0];
      2'd1:    perm_bit = cur_cfg[1];
      2'd2:    perm_bit = cur_cfg[2];
      default: perm_bit = 1'b0;
    endcase
  end

  assign entry_allow = (priv_reg && !cur_cfg[7]) || perm_bit;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (req_valid) state_next = SCAN;
      SCAN: if (size_bad || any_match || last_entry) state_next = RESP;
      RESP: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    req_ready = (state_reg == IDLE);
    cfg_ready = (state_reg == IDLE);
    rsp_valid = (state_reg == RESP);
  end

  // Request capture, scan stepping and response latching.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg     <= 32'h0;
      size_reg     <= 2'd0;
      type_reg     <= 2'd0;
      priv_reg     <= 1'b0;
      scan_idx_reg <= '0;
      rsp_allow    <= 1'b0;
      rsp_hit      <= 1'b0;
      rsp_hit_idx  <= '0;
    end else begin
      if (state_reg == IDLE && req_valid) begin
        addr_reg     <= req_addr;
        size_reg     <= req_size;
        type_reg     <= req_type;
        priv_reg     <= req_priv_m;
        scan_idx_reg <= '0;
      end else if (state_reg == SCAN) begin
        if (size_bad) begin
          rsp_hit     <= 1'b0;
          rsp_hit_idx <= '0;
          rsp_allow   <= 1'b0;
        end else if (any_match) begin
          rsp_hit     <= 1'b1;
          rsp_hit_idx <= scan_idx_reg;
          rsp_allow   <= full_match && entry_allow;
        end else if (last_entry) begin
          rsp_hit     <= 1'b0;
          rsp_hit_idx <= '0;
          rsp_allow   <= priv_reg;
        end else begin
          scan_idx_reg <= scan_idx_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pmp_checker.sv
// Testbench for pmp_checker: table of request vectors grouped into config phases,
// a scoreboard queue of expected responses, and hand-written handshake/reset sequences.
module tb_pmp_checker;
  localparam int N     = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [7:0]       cfg_wdata;
  logic             addr_we;
  logic [IDX_W-1:0] addr_idx;
  logic [31:0]      addr_wdata;
  logic             cfg_ready;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_addr;
  logic [1:0]       req_size;
  logic [1:0]       req_type;
  logic             req_priv_m;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_allow;
  logic             rsp_hit;
  logic [IDX_W-1:0] rsp_hit_idx;

  pmp_checker #(.NUM_ENTRIES(N), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_wdata(cfg_wdata),
    .addr_we(addr_we), .addr_idx(addr_idx), .addr_wdata(addr_wdata),
    .cfg_ready(cfg_ready),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_type(req_type), .req_priv_m(req_priv_m),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_allow(rsp_allow),
    .rsp_hit(rsp_hit), .rsp_hit_idx(rsp_hit_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          phase;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [1:0]  typ;
    logic        priv;
    logic        hit;
    logic [2:0]  idx;
    logic        allow;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int ph, input logic [31:0] a, input logic [1:0] sz,
                     input logic [1:0] ty, input logic pv, input logic h,
                     input logic [2:0] ix, input logic al, input int lt);
    vec_t v;
    v = '{ph, a, sz, ty, pv, h, ix, al, lt};
    vecs.push_back(v);
  endtask

  task automatic wr(input logic ce, input logic [2:0] ci, input logic [7:0] cd,
                    input logic ae, input logic [2:0] ai, input logic [31:0] ad);
    cfg_we = ce; cfg_idx = ci; cfg_wdata = cd;
    addr_we = ae; addr_idx = ai; addr_wdata = ad;
    step();
    cfg_we = 1'b0; addr_we = 1'b0;
  endtask

  task automatic issue(input vec_t v);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("req_ready_wait", {63'd0, req_ready}, 64'd1);
    req_addr = v.addr; req_size = v.size; req_type = v.typ; req_priv_m = v.priv;
    req_valid = 1'b1;
    sb.push_back(v);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int lat;
    vec_t e;
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      step();
      lat++;
    end
    if (sb.size() == 0) begin
      check("sb_empty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      $display("[TB] req addr=%08h size=%0d type=%0d m=%0d -> hit=%0d idx=%0d allow=%0d lat=%0d",
               e.addr, e.size, e.typ, e.priv, rsp_hit, rsp_hit_idx, rsp_allow, lat);
      check("latency", lat, e.lat);
      check("rsp_hit", {63'd0, rsp_hit}, {63'd0, e.hit});
      check("rsp_hit_idx", {61'd0, rsp_hit_idx}, {61'd0, e.idx});
      check("rsp_allow", {63'd0, rsp_allow}, {63'd0, e.allow});
    end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("idle_after_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("idle_after_rsp_ready", {63'd0, req_ready}, 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    issue(v);
    wait_rsp();
    release_rsp();
  endtask

  task automatic setup(input int ph);
    case (ph)
      1: begin
        wr(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 32'h400);
        wr(1'b1, 3'd0, 8'h09, 1'b0, 3'd0, 32'h0);            // TOR|R
      end
      2: begin
        wr(1'b1, 3'd1, 8'h12, 1'b1, 3'd1, 32'h800);          // NA4|W at 0x2000
        wr(1'b1, 3'd3, 8'h1F, 1'b1, 3'd3, 32'h9FF);          // NAPOT|RWX 0x2000-0x2FFF
      end
      3: begin
        wr(1'b1, 3'd2, 8'h91, 1'b1, 3'd2, 32'h1000);         // L|NA4|R at 0x4000
        wr(1'b1, 3'd2, 8'h00, 1'b1, 3'd2, 32'h2000);         // both dropped (locked)
        wr(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 32'h1400);
        wr(1'b1, 3'd5, 8'h8C, 1'b1, 3'd5, 32'h1800);         // L|TOR|X 0x5000-0x5FFF
        wr(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 32'h1700);         // dropped: TOR lock above
      end
      default: ;
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int cur;
    int seen;
    vec_t v;
    logic [2:0] snap_idx;
    logic snap_hit, snap_allow;

    rst = 1'b1;
    cfg_we = 0; cfg_idx = 0; cfg_wdata = 0;
    addr_we = 0; addr_idx = 0; addr_wdata = 0;
    req_valid = 0; req_addr = 0; req_size = 0; req_type = 0; req_priv_m = 0;
    rsp_ready = 0;

    // phase 0: reset configuration
    add(0, 32'h1000, 2'd2, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 8);
    add(0, 32'h1000, 2'd2, 2'd0, 1'b1, 1'b0, 3'd0, 1'b1, 8);
    add(0, 32'h1000, 2'd3, 2'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1);
    // phase 1: TOR entry 0 over [0, 0x1000)
    add(1, 32'h0FFC, 2'd2, 2'd0, 1'b0, 1'b1, 3'd0, 1'b1, 1);
    add(1, 32'h0FFE, 2'd2, 2'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1);
    add(1, 32'h0000, 2'd0, 2'd1, 1'b0, 1'b1, 3'd0, 1'b0, 1);
    add(1, 32'h0010, 2'd0, 2'd1, 1'b1, 1'b1, 3'd0, 1'b1, 1);
    add(1, 32'h1000, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 8);
    // phase 2: priority NA4 entry 1 vs NAPOT entry 3
    add(2, 32'h2000, 2'd2, 2'd1, 1'b0, 1'b1, 3'd1, 1'b1, 2);
    add(2, 32'h2000, 2'd2, 2'd0, 1'b0, 1'b1, 3'd1, 1'b0, 2);
    add(2, 32'h2003, 2'd1, 2'd2, 1'b0, 1'b1, 3'd1, 1'b0, 2);
`ifdef PMP_NAPOT_EN
    add(2, 32'h2800, 2'd2, 2'd0, 1'b0, 1'b1, 3'd3, 1'b1, 4);
    add(2, 32'h2FFE, 2'd2, 2'd0, 1'b0, 1'b1, 3'd3, 1'b0, 4);
`else
    add(2, 32'h2800, 2'd2, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 8);
    add(2, 32'h2FFE, 2'd2, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 8);
`endif
    // phase 3: locked entries
    add(3, 32'h4000, 2'd2, 2'd1, 1'b1, 1'b1, 3'd2, 1'b0, 3);
    add(3, 32'h4000, 2'd2, 2'd0, 1'b1, 1'b1, 3'd2, 1'b1, 3);
    add(3, 32'h5000, 2'd0, 2'd2, 1'b0, 1'b1, 3'd5, 1'b1, 6);
    add(3, 32'h5FFF, 2'd0, 2'd0, 1'b1, 1'b1, 3'd5, 1'b0, 6);
    add(3, 32'h6000, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 8);

    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset_req_ready", {63'd0, req_ready}, 64'd1);
    check("reset_cfg_ready", {63'd0, cfg_ready}, 64'd1);
    check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("reset_rsp_hit", {63'd0, rsp_hit}, 64'd0);
    check("reset_rsp_allow", {63'd0, rsp_allow}, 64'd0);
    check("reset_rsp_hit_idx", {61'd0, rsp_hit_idx}, 64'd0);

    cur = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].phase != cur) begin
        cur = vecs[i].phase;
        setup(cur);
      end
      run_vec(vecs[i]);
    end

    // Handshake: hold the response for five cycles while pushing writes and requests.
    v = '{4, 32'h2000, 2'd2, 2'd0, 1'b0, 1'b1, 3'd1, 1'b0, 2};
    issue(v);
    wait_rsp();
    snap_hit = rsp_hit; snap_idx = rsp_hit_idx; snap_allow = rsp_allow;
    for (int c = 0; c < 5; c++) begin
      req_valid = 1'b1; req_addr = 32'h0; req_size = 2'd0; req_type = 2'd0; req_priv_m = 1'b1;
      cfg_we = 1'b1; cfg_idx = 3'd6; cfg_wdata = 8'h11;
      addr_we = 1'b1; addr_idx = 3'd6; addr_wdata = 32'h2400;
      step();
      check("hold_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      check("hold_rsp_hit", {63'd0, rsp_hit}, {63'd0, snap_hit});
      check("hold_rsp_hit_idx", {61'd0, rsp_hit_idx}, {61'd0, snap_idx});
      check("hold_rsp_allow", {63'd0, rsp_allow}, {63'd0, snap_allow});
      check("hold_req_ready", {63'd0, req_ready}, 64'd0);
      check("hold_cfg_ready", {63'd0, cfg_ready}, 64'd0);
    end
    req_valid = 1'b0; cfg_we = 1'b0; addr_we = 1'b0;
    release_rsp();
    // Dropped entry-6 writes would have made this a hit at idx 6.
    v = '{4, 32'h9000, 2'd2, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 8};
    run_vec(v);

    // Reset in the middle of a scan discards the request.
    v = '{5, 32'h9000, 2'd2, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 8};
    issue(v);
    step();
    step();
    #3 rst = 1'b1;
    #1;
    check("midscan_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("midscan_rst_req_ready", {63'd0, req_ready}, 64'd1);
    sb.delete();
    step();
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (rsp_valid) seen++;
    end
    check("midscan_no_response", seen, 0);

    // Locks cleared by reset: entry 2 no longer matches.
    v = '{6, 32'h4000, 2'd2, 2'd1, 1'b1, 1'b0, 3'd0, 1'b1, 8};
    run_vec(v);

    // NAPOT all-ones entry 0, cfg and addr written in the same cycle.
    wr(1'b1, 3'd0, 8'h1F, 1'b1, 3'd0, 32'hFFFF_FFFF);
`ifdef PMP_NAPOT_EN
    v = '{7, 32'h1000, 2'd2, 2'd0, 1'b0, 1'b1, 3'd0, 1'b1, 1};
`else
    v = '{7, 32'h1000, 2'd2, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 8};
`endif
    run_vec(v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pmp_checker.md
PMP_CHECKER -- requirements
Module: pmp_checker

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 8, number of PMP entries; legal range 1..16.
REQ-002 SHALL have parameter IDX_W, default 3, entry index width; SHALL equal max(1, clog2(NUM_ENTRIES)).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have ports cfg_we  input  1; cfg_idx  input  IDX_W; cfg_wdata  input  8  entry config {L,2'b0,A[1:0],X,W,R}.
REQ-006 SHALL have ports addr_we  input  1; addr_idx  input  IDX_W; addr_wdata  input  32  pmpaddr, byte address bits [33:2].
REQ-007 SHALL have port cfg_ready  output  1  register writes accepted.
REQ-008 SHALL have ports req_valid  input  1; req_ready  output  1; req_addr  input  32; req_size  input  2 (0 byte, 1 half, 2 word; 3 illegal); req_type  input  2 (0 R, 1 W, 2 X); req_priv_m  input  1.
REQ-009 SHALL have ports rsp_valid  output  1; rsp_ready  input  1; rsp_allow  output  1; rsp_hit  output  1; rsp_hit_idx  output  IDX_W.

Function
REQ-010 SHALL implement FSM IDLE, SCAN, RESP; req_ready = cfg_ready = (state==IDLE); rsp_valid = (state==RESP).
REQ-011 IDLE: on req_valid SHALL capture request, set scan index 0, go SCAN.
REQ-012 SCAN: SHALL evaluate exactly one entry per cycle in ascending index order, lowest index taking priority.
REQ-013 Access span SHALL be byte range [a, a+2^size-1], with a = req_addr zero-extended to 34 bits; size 3 SHALL be denied immediately (rsp_hit=0).
REQ-014 A=0 OFF SHALL never match. A=1 TOR: [{pmpaddr[i-1],2'b00}, {pmpaddr[i],2'b00}); entry 0 lower bound SHALL be 0. A=2 NA4: 4 bytes at {pmpaddr[i],2'b00}. A=3 NAPOT: t trailing ones in pmpaddr[i] give 2^(t+3)-byte aligned region; all ones SHALL cover the whole 34-bit space.
REQ-015 Full match SHALL go RESP with rsp_hit=1, rsp_hit_idx=i, rsp_allow = (req_priv_m && !L) || cfg permission bit selected by req_type.
REQ-016 Partial match (some bytes inside) SHALL go RESP with rsp_hit=1, rsp_hit_idx=i, rsp_allow=0.
REQ-017 No match after entry NUM_ENTRIES-1 SHALL go RESP with rsp_hit=0, rsp_hit_idx=0, rsp_allow=req_priv_m.
REQ-018 Latency: decided at entry k, rsp_valid SHALL assert k+1 cycles after the accepting edge.
REQ-019 RESP: outputs SHALL hold stable until rsp_ready; on rsp_valid&&rsp_ready SHALL go IDLE; no new request accepted in the same cycle.
REQ-020 Writes SHALL take effect only when cfg_ready=1; writes with cfg_ready=0 SHALL be dropped.
REQ-021 Writes to cfg[i] or pmpaddr[i] SHALL be ignored when cfg[i].L=1; pmpaddr[i] writes also ignored when cfg[i+1].L=1 and cfg[i+1].A=TOR.
REQ-022 Simultaneous cfg and addr writes SHALL both be applied, each lock-checked against pre-write cfg values; out-of-range indices SHALL be ignored.

Reset
REQ-023 rst SHALL force state IDLE, all cfg to 0 (OFF, unlocked), all pmpaddr to 0, rsp_valid/rsp_allow/rsp_hit/rsp_hit_idx to 0, asynchronously at any state.
REQ-024 Reset mid-SCAN or mid-RESP SHALL discard the in-flight request with no response; L bits SHALL clear only by reset.

Configuration
REQ-025 Macro PMP_NAPOT_EN defined: A=3 SHALL decode per REQ-014; undefined: A=3 SHALL behave as OFF and NAPOT logic SHALL be absent.

Verification
REQ-026 Reset state: cfg0 OFF, U-mode read 0x1000 -> rsp_hit=0, allow=0, rsp_valid NUM_ENTRIES cycles after accept; M-mode -> allow=1.
REQ-027 TOR: pmpaddr0=0x400 (0x1000), cfg0=TOR|R; U read word 0x0FFC -> hit idx0 allow=1; 0x0FFE size 2 -> partial, allow=0.
REQ-028 Priority: cfg1=NA4|W at 0x2000, cfg3=NAPOT|RWX over 0x2000-0x2FFF; U write 0x2000 -> idx1, allow=1, rsp_valid 2 cycles after accept; U read -> idx1, allow=0.
REQ-029 Lock: cfg2=L|NA4|R; rewrite cfg2=0 -> ignored; M-mode write to region -> allow=0; reset -> cfg2 reads OFF.
REQ-030 Handshake: hold rsp_ready=0 five cycles -> outputs stable, req_ready=0, cfg writes dropped; assert rsp_ready -> IDLE next cycle.
REQ-031 Build without PMP_NAPOT_EN: cfg0=NAPOT|RWX pmpaddr0=all ones, U read -> rsp_hit=0, allow=0.
